add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_add_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//
// Purpose:
//   Sequential multi-word adder controller. An N-bit addition (N = 3*WORDS)
//   is split into WORDS 3-bit slices that are fed one per cycle through an
//   external 3-bit full-adder stage. The ripple carry between slices is held
//   in a carry register, so a full operation takes WORDS cycles in RUN. A
//   valid/ready handshake sits on both the operand and the result side.
//
// Parameters:
//   WORDS     number of 3-bit slices per operand (N = 3*WORDS), WORDS >= 1
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand set offered
//   in_ready  block accepts operand set (high only in IDLE)
//   in_a      operand A, N bits
//   in_b      operand B, N bits
//   in_cin    carry into slice 0
//   out_valid result available (high only in DONE)
//   out_ready consumer takes result
//   out_sum   N-bit sum, held stable while in DONE
//   out_cout  carry out of the top slice
//   add_a     3-bit slice of A to the external adder (0 outside RUN)
//   add_b     3-bit slice of B to the external adder (0 outside RUN)
//   add_cin   carry into the external adder (0 outside RUN)
//   add_sum   3-bit sum returned by the external adder
//   add_cout  per-bit carry vector from the adder; only bit 2 is used
// -----------------------------------------------------------------------------
module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*WORDS-1:0] in_a,
  input  logic [3*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic [2:0]         add_a,
  output logic [2:0]         add_b,
  output logic               add_cin,
  input  logic [2:0]         add_sum,
  input  logic [2:0]         add_cout
);

  localparam int N = 3 * WORDS;
  // A 1-bit index is still needed when WORDS=1 so the vector is never empty.
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [N-1:0]     opA_q;
  logic [N-1:0]     opB_q;
  logic [N-1:0]     sum_q;
  logic [N-1:0]     sum_d;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       sliceA;
  logic [2:0]       sliceB;
  logic             unusedCoutBits;

  // Only the top carry of the adder stage leaves a slice; the lower
  // per-bit carries are internal to the 3-bit stage.
  assign unusedCoutBits = ^add_cout[1:0];

  // Select the operand slice addressed by the current index and build the
  // next sum value with the freshly returned adder result written into that
  // same slice. A compare-per-slice loop avoids a variable part-select.
  always_comb begin
    sliceA = 3'b000;
    sliceB = 3'b000;
    sum_d  = sum_q;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        sliceA           = opA_q[3*w +: 3];
        sliceB           = opB_q[3*w +: 3];
        sum_d[3*w +: 3]  = add_sum;
      end
    end
  end

  // Adder stage is only driven while RUN so it sees quiet zeros otherwise.
  assign add_a   = (state_q == RUN) ? sliceA : 3'b000;
  assign add_b   = (state_q == RUN) ? sliceB : 3'b000;
  assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  // Control FSM and datapath registers. Reset drops any in-flight operation
  // and clears the result so no stale value is ever presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q   <= in_a;
            opB_q   <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= add_cout[2];
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            cout_q  <= add_cout[2];
            state_q <= DONE;
          end
        end
        DONE: begin
          // New operands are deliberately not looked at here; the next
          // accept can only happen once the FSM is back in IDLE.
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
//
// Self-checking bench for add_seq_ctrl with WORDS=4. A behavioural 3-bit
// full adder answers the DUT's adder-stage port. Expected results are pushed
// into a scoreboard queue when an operand set is accepted and popped when the
// DUT presents a result.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

  localparam int WORDS = 4;
  localparam int N     = 3 * WORDS;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic [2:0]   add_a;
  logic [2:0]   add_b;
  logic         add_cin;
  logic [2:0]   add_sum;
  logic [2:0]   add_cout;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cycleCount;
  int   acceptEdge;
  int   handshakeEdge;

  add_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure handshake spacing.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural 3-bit ripple full adder with a per-bit carry vector.
  always_comb begin
    logic c0, c1, c2;
    c0 = (add_a[0] & add_b[0]) | (add_cin & (add_a[0] ^ add_b[0]));
    c1 = (add_a[1] & add_b[1]) | (c0 & (add_a[1] ^ add_b[1]));
    c2 = (add_a[2] & add_b[2]) | (c1 & (add_a[2] ^ add_b[2]));
    add_sum  = add_a ^ add_b ^ {c1, c0, add_cin};
    add_cout = {c2, c1, c0};
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer an operand set, wait (bounded) for the accept edge and push the
  // expected result. Returns just after the accept edge.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic cin, input bit keepValid);
    logic [N:0] full;
    exp_t       e;
    int         n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $error("[TB] FAIL accept_timeout observed=in_ready_low required=in_ready_high");
      return;
    end
    step();
    acceptEdge = cycleCount;
    full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    e.sum  = full[N-1:0];
    e.cout = full[N];
    sb.push_back(e);
    if (!keepValid) in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head and
  // complete the result handshake. Returns just after the handshake edge.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_timeout observed=out_valid_low required=out_valid_high", tag);
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_unexpected observed=result required=none", tag);
      return;
    end
    e = sb.pop_front();
    checkValue({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
    checkValue({tag, "_cout"}, 32'(out_cout), 32'(e.cout));
    out_ready = 1'b1;
    step();
    handshakeEdge = cycleCount;
    out_ready = 1'b0;
    checkValue({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    exp_t head;
    bit   sawValid;
    checks     = 0;
    failures   = 0;
    cycleCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_cin     = 1'b0;
    out_ready  = 1'b0;

    // Reset state, with operands already offered for the first accept.
    step();
    step();
    checkValue("rst_in_ready",  32'(in_ready),  32'd1);
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_out_sum",   32'(out_sum),   32'd0);
    checkValue("rst_out_cout",  32'(out_cout),  32'd0);
    checkValue("rst_add_a",     32'(add_a),     32'd0);
    checkValue("rst_add_b",     32'(add_b),     32'd0);
    checkValue("rst_add_cin",   32'(add_cin),   32'd0);
    in_valid = 1'b1;
    in_a     = 12'h123;
    in_b     = 12'h456;
    rst_n    = 1'b1;

    // 0x123 + 0x456: accepted on first edge after release, 4-edge latency.
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b0);
    checkValue("first_accept_edge", 32'(acceptEdge), 32'd3);
    checkValue("run_in_ready", 32'(in_ready), 32'd0);
    checkValue("run_add_a0",   32'(add_a),    32'd3);
    checkValue("run_add_b0",   32'(add_b),    32'd6);
    checkValue("run_add_cin0", 32'(add_cin),  32'd0);
    for (int i = 1; i < WORDS; i++) begin
      step();
      checkValue("lat_valid_low", 32'(out_valid), 32'd0);
    end
    step();
    checkValue("lat_valid_high", 32'(out_valid), 32'd1);
    checkOutput("op_579");

    // Carry ripples through every slice.
    applyStimulus(12'hFFF, 12'h001, 1'b0, 1'b0);
    checkOutput("op_ripple");

    // All ones plus carry-in.
    applyStimulus(12'hFFF, 12'hFFF, 1'b1, 1'b0);
    checkOutput("op_max");

    // Back-pressure in DONE with new operands waiting.
    applyStimulus(12'hABC, 12'h123, 1'b0, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) step();
    in_valid = 1'b1;
    in_a     = 12'h010;
    in_b     = 12'h020;
    in_cin   = 1'b0;
    head = sb[0];
    for (int i = 0; i < 3; i++) begin
      step();
      checkValue("hold_sum",      32'(out_sum),   32'(head.sum));
      checkValue("hold_cout",     32'(out_cout),  32'(head.cout));
      checkValue("hold_in_ready", 32'(in_ready),  32'd0);
      checkValue("hold_valid",    32'(out_valid), 32'd1);
    end
    checkOutput("op_hold");
    checkValue("hs_idle_ready", 32'(in_ready), 32'd1);
    applyStimulus(12'h010, 12'h020, 1'b0, 1'b0);
    checkOutput("op_after_hold");

    // Reset in the middle of RUN, at slice index 2.
    applyStimulus(12'h555, 12'h222, 1'b0, 1'b0);
    step();
    step();
    checkValue("mid_add_a2", 32'(add_a), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("mid_rst_ready", 32'(in_ready),  32'd1);
    checkValue("mid_rst_valid", 32'(out_valid), 32'd0);
    checkValue("mid_rst_add_a", 32'(add_a),     32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    step();
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) sawValid = 1'b1;
    end
    checkValue("post_rst_no_valid", 32'(sawValid), 32'd0);
    checkValue("post_rst_ready",    32'(in_ready), 32'd1);
    applyStimulus(12'h007, 12'h001, 1'b0, 1'b0);
    checkOutput("op_after_rst");

    // in_valid held high across two back-to-back operations.
    applyStimulus(12'h111, 12'h222, 1'b0, 1'b1);
    checkOutput("op_333");
    in_a = 12'h800;
    in_b = 12'h800;
    checkValue("b2b_idle_ready", 32'(in_ready), 32'd1);
    applyStimulus(12'h800, 12'h800, 1'b0, 1'b0);
    checkValue("b2b_gap", 32'(acceptEdge - handshakeEdge), 32'd1);
    checkOutput("op_800");

    // A few random operand sets.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(N'($urandom_range(0, 4095)), N'($urandom_range(0, 4095)),
                    1'($urandom_range(0, 1)), 1'b0);
      checkOutput("op_rand");
    end

    checkValue("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
